// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit: one outstanding imem request, hold buffer, redirect handling
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   imem_read            instruction-memory read request
//   imem_address         word-aligned read address, stable until imem_resp
//   imem_rdata           read data, valid with imem_resp
//   imem_resp            one-cycle read-complete pulse
//   stall_i              IF/ID register not loading this cycle
//   redirect_i           branch/jump/flush redirect (highest priority)
//   redirect_pc_i        redirect target (low two bits ignored)
//   valid_o              pc_o/instruction_o carry a fetched instruction
//   pc_o                 PC of the presented instruction
//   instruction_o        presented instruction word
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instruction_o
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic [31:0] redirect_target;

    assign redirect_target = redirect_pc_i & ~32'h0000_0003;

    // Outputs are decoded from state so a response can be forwarded to
    // IF/ID in the very cycle it arrives; reset forces everything quiet.
    always_comb begin
        imem_read     = 1'b0;
        imem_address  = pc;
        valid_o       = 1'b0;
        pc_o          = 32'h0;
        instruction_o = 32'h0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    imem_read     = 1'b1;
                    imem_address  = pc;
                    valid_o       = imem_resp && !redirect_i;
                    pc_o          = pc;
                    instruction_o = imem_rdata;
                end
                HOLD: begin
                    imem_read     = 1'b0;
                    imem_address  = pc;
                    valid_o       = !redirect_i;
                    pc_o          = hold_pc;
                    instruction_o = hold_instr;
                end
                DISCARD: begin
                    // pc may already point at a redirect target; the bus must
                    // keep showing the stale request until it completes.
                    imem_read     = 1'b1;
                    imem_address  = req_addr;
                    valid_o       = 1'b0;
                    pc_o          = pc;
                    instruction_o = imem_rdata;
                end
                default: begin
                    imem_read     = 1'b0;
                    imem_address  = pc;
                    valid_o       = 1'b0;
                    pc_o          = 32'h0;
                    instruction_o = 32'h0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            hold_pc    <= 32'h0;
            hold_instr <= 32'h0;
        end else begin
            case (state)
                FETCH: begin
                    req_addr <= pc;
                    if (redirect_i) begin
                        pc    <= redirect_target;
                        // Without a response this cycle the old request is
                        // still in flight and its data must be dropped later.
                        state <= imem_resp ? FETCH : DISCARD;
                    end else if (imem_resp) begin
                        if (!stall_i) begin
                            pc <= pc + 32'd4;
                        end else begin
                            hold_pc    <= pc;
                            hold_instr <= imem_rdata;
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        pc    <= redirect_target;
                        state <= FETCH;
                    end else if (!stall_i) begin
                        pc    <= hold_pc + 32'd4;
                        state <= FETCH;
                    end
                end
                DISCARD: begin
                    if (redirect_i) begin
                        pc <= redirect_target;
                    end
                    if (imem_resp) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule
